// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// and buffers returned words in a 2-entry FIFO presented to the IF/ID register.
module if_fetch_unit #(
    parameter int                WORD_W   = 32,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instrF,
    output logic [WORD_W-1:0] pcF,
    output logic              validF
);

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;
    localparam logic [WORD_W-1:0] PC_STEP   = WORD_W'(4);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e            state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] reqPc_q;
    logic              drop_q;
    logic [1:0]        count_q, count_d;
    logic [WORD_W-1:0] qPc_q    [2];
    logic [WORD_W-1:0] qInstr_q [2];
    logic [WORD_W-1:0] qPc_d    [2];
    logic [WORD_W-1:0] qInstr_d [2];
    logic              push;
    logic              pop;

    assign validF    = (count_q != 2'd0);
    assign instrF    = validF ? qInstr_q[0] : ZERO_WORD;
    assign pcF       = validF ? qPc_q[0] : ZERO_WORD;
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == S_IDLE) && (count_q < 2'd2) && !redirect && !rst;

    // Entry 0 is always the head; a pop shifts entry 1 down so order is preserved.
    always_comb begin
        push        = (state_q == S_WAIT) && imem_rvalid && !drop_q;
        pop         = validF && !stallF;
        count_d     = count_q;
        qPc_d[0]    = qPc_q[0];
        qPc_d[1]    = qPc_q[1];
        qInstr_d[0] = qInstr_q[0];
        qInstr_d[1] = qInstr_q[1];
        if (push && pop) begin
            if (count_q == 2'd2) begin
                qPc_d[0]    = qPc_q[1];
                qInstr_d[0] = qInstr_q[1];
                qPc_d[1]    = reqPc_q;
                qInstr_d[1] = imem_rdata;
            end else begin
                qPc_d[0]    = reqPc_q;
                qInstr_d[0] = imem_rdata;
            end
        end else if (pop) begin
            qPc_d[0]    = qPc_q[1];
            qInstr_d[0] = qInstr_q[1];
            count_d     = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                qPc_d[0]    = reqPc_q;
                qInstr_d[0] = imem_rdata;
            end else begin
                qPc_d[1]    = reqPc_q;
                qInstr_d[1] = imem_rdata;
            end
            count_d = count_q + 2'd1;
        end
    end

    // A redirect during WAIT cannot cancel the memory access, so drop_q marks its
    // response to be swallowed when it eventually returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            reqPc_q     <= ZERO_WORD;
            drop_q      <= 1'b0;
            count_q     <= 2'd0;
            qPc_q[0]    <= ZERO_WORD;
            qPc_q[1]    <= ZERO_WORD;
            qInstr_q[0] <= ZERO_WORD;
            qInstr_q[1] <= ZERO_WORD;
        end else if (redirect) begin
            count_q <= 2'd0;
            pc_q    <= redirect_pc;
            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    state_q <= S_IDLE;
                    drop_q  <= 1'b0;
                end else begin
                    drop_q <= 1'b1;
                end
            end
        end else begin
            count_q     <= count_d;
            qPc_q[0]    <= qPc_d[0];
            qPc_q[1]    <= qPc_d[1];
            qInstr_q[0] <= qInstr_d[0];
            qInstr_q[1] <= qInstr_d[1];
            case (state_q)
                S_IDLE: begin
                    if (imem_req && imem_gnt) begin
                        reqPc_q <= pc_q;
                        pc_q    <= pc_q + PC_STEP;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
